// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply/divide: one bit per cycle, single operation in flight.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIVU/REMU complete with zero.
module muldiv_iter #(
  parameter int unsigned ANCHO = 32,
  parameter int unsigned LARGO = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [ANCHO-1:0] rs1_i,
  input  logic [ANCHO-1:0] rs2_i,
  input  logic [LARGO-1:0] rd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             we_o,
  output logic [LARGO-1:0] addr_rd_o,
  output logic [ANCHO-1:0] data_o
);

  localparam int unsigned CntW = $clog2(ANCHO + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(ANCHO);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [ANCHO-1:0]   opnd_q, opnd_d;
  logic [2*ANCHO-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [LARGO-1:0]   rd_q, rd_d;
  logic [ANCHO-1:0]   data_q, data_d;
  logic [LARGO-1:0]   addr_q, addr_d;
  logic               done_q, done_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;

  logic [ANCHO:0]     mul_sum;
  logic [ANCHO-1:0]   result;

  // Multiply: acc holds {partial product, remaining bits of B}; opnd holds A.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*ANCHO-1:ANCHO]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  end

`ifdef MULDIV_DIV_EN
  logic [ANCHO-1:0] rem_q, rem_d;
  logic [ANCHO:0]   rem_sh;
  logic [ANCHO-1:0] rem_sub;
  logic             q_bit;

  // Divide: acc low half shifts dividend out and quotient in; opnd holds the divisor.
  // The stored remainder is always below the divisor, so ANCHO bits suffice.
  always_comb begin
    rem_sh  = {rem_q, acc_q[ANCHO-1]};
    q_bit   = (rem_sh >= {1'b0, opnd_q});
    rem_sub = rem_sh[ANCHO-1:0] - opnd_q;
  end
`endif

  always_comb begin
    result = '0;
    case (op_q)
      2'b00:   result = acc_q[ANCHO-1:0];
      2'b01:   result = acc_q[2*ANCHO-1:ANCHO];
`ifdef MULDIV_DIV_EN
      2'b10:   result = acc_q[ANCHO-1:0];
      2'b11:   result = rem_q;
`endif
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    data_d  = data_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    busy_d  = done_q ? 1'b0 : busy_q;
`ifdef MULDIV_DIV_EN
    rem_d   = rem_q;
`endif

    case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d    = op_i;
          rd_d    = rd_i;
          opnd_d  = op_i[1] ? rs2_i : rs1_i;
          acc_d   = {{ANCHO{1'b0}}, (op_i[1] ? rs1_i : rs2_i)};
          cnt_d   = CntInit;
          busy_d  = 1'b1;
          state_d = StRun;
`ifdef MULDIV_DIV_EN
          rem_d   = '0;
`else
          if (op_i[1]) begin
            state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntLast;
`ifdef MULDIV_DIV_EN
        if (op_q[1]) begin
          rem_d = q_bit ? rem_sub : rem_sh[ANCHO-1:0];
          acc_d = {acc_q[2*ANCHO-1:ANCHO], acc_q[ANCHO-2:0], q_bit};
        end else begin
          acc_d = {mul_sum, acc_q[ANCHO-1:1]};
        end
`else
        acc_d = {mul_sum, acc_q[ANCHO-1:1]};
`endif
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        data_d  = result;
        addr_d  = rd_q;
        done_d  = 1'b1;
        we_d    = (rd_q != '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end
`endif

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign we_o      = we_q;
  assign addr_rd_o = addr_q;
  assign data_o    = data_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: fixed vectors, random ops against an arithmetic model, corner sequences.
// Honours MULDIV_DIV_EN the same way the design does.
module tb_muldiv_iter;

  localparam int unsigned W = 32;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        done_o;
  logic        we_o;
  logic [4:0]  addr_rd_o;
  logic [31:0] data_o;

  int total = 0;
  int bad   = 0;

  muldiv_iter #(
    .ANCHO(32),
    .LARGO(5)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .we_o     (we_o),
    .addr_rd_o(addr_rd_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00: return p[31:0];
      2'b01: return p[63:32];
`ifdef MULDIV_DIV_EN
      2'b10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_DIV_EN
    return W + 1;
`else
    return op[1] ? 1 : W + 1;
`endif
  endfunction

  // Cycles from the acceptance sample until done_o is seen, bounded.
  task automatic wait_done(output int n, output int busy_err);
    n = 0;
    busy_err = 0;
    while (n < 100) begin
      @(posedge clk_i); #1;
      n++;
      if (!busy_o) busy_err++;
      if (done_o) break;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input string tag);
    int n;
    int busy_err;
    logic [31:0] held;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    @(posedge clk_i); #1;
    start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
    check($sformatf("%s/busy_rise", tag), 64'(busy_o), 64'd1);
    wait_done(n, busy_err);
    check($sformatf("%s/latency", tag), 64'(n), 64'(exp_lat(op)));
    check($sformatf("%s/busy_in_flight", tag), 64'(busy_err), 64'd0);
    check($sformatf("%s/data", tag), 64'(data_o), 64'(exp));
    check($sformatf("%s/we", tag), 64'(we_o), 64'(rd != 0));
    check($sformatf("%s/addr", tag), 64'(addr_rd_o), 64'(rd));
    held = data_o;
    @(posedge clk_i); #1;
    check($sformatf("%s/done_fall", tag), 64'({done_o, we_o, busy_o}), 64'd0);
    check($sformatf("%s/data_hold", tag), 64'({addr_rd_o, data_o}), 64'({rd, held}));
  endtask

  initial begin
    int n;
    int busy_err;
    int seen;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] e;

    vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 32'h0000_0001};
    vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd2,  32'd14};
    vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd3,  32'd2};
    vecs[5] = '{2'b10, 32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF};
    vecs[6] = '{2'b11, 32'd5,          32'd0,          5'd6,  32'd5};
    vecs[7] = '{2'b01, 32'h8000_0000,  32'd4,          5'd7,  32'd2};
    vecs[8] = '{2'b11, 32'hFFFF_FFFF,  32'h1_0000,     5'd8,  32'h0000_FFFF};
    vecs[9] = '{2'b10, 32'd3,          32'd9,          5'd9,  32'd0};

    reset_i = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) reset_i = 1'b0;
    #1;
    check("reset_outputs", 64'({busy_o, done_o, we_o, addr_rd_o, data_o}), 64'd0);

    for (int i = 0; i < 10; i++) begin
`ifdef MULDIV_DIV_EN
      e = vecs[i].exp;
`else
      e = vecs[i].op[1] ? 32'h0 : vecs[i].exp;
`endif
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
      rd = 5'($urandom);
      run_op(op, a, b, rd, ref_model(op, a, b), $sformatf("rnd%0d", i));
    end

    // rd=0 suppresses we_o; a start pulse and operand churn mid-RUN must be ignored.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd3; rs2_i = 32'd3; rd_i = 5'd0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b10; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd9;
    @(negedge clk_i);
    start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom;
    wait_done(n, busy_err);
    check("rd0/latency", 64'(n), 64'(W + 1 - 6));
    check("rd0/data", 64'(data_o), 64'd9);
    check("rd0/we", 64'(we_o), 64'd0);
    check("rd0/addr", 64'(addr_rd_o), 64'd0);
    seen = 0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) seen++;
    end
    check("rd0/no_second_op", 64'(seen), 64'd0);

    // Preload nonzero outputs, then reset 10 cycles into a DIVU.
    run_op(2'b00, 32'd5, 32'd5, 5'd4, 32'd25, "pre_reset");
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b10; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i) reset_i = 1'b1;
    #1;
    check("reset_mid/outputs", 64'({busy_o, done_o, we_o, addr_rd_o, data_o}), 64'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (done_o || we_o) seen++;
    end
    @(negedge clk_i) reset_i = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o || we_o || busy_o) seen++;
    end
    check("reset_mid/no_done", 64'(seen), 64'd0);
    run_op(2'b00, 32'd2, 32'd2, 5'd3, 32'd4, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative unsigned multiply/divide unit in the execute stage, downstream of the register file. Takes the two source operands read from the register file plus a destination index, runs a one-bit-per-cycle shift-add multiply or restoring divide, and returns the result with a write-enable and destination address that drive the register file write port (`data_in`/`we_i`/`addr_rd`) directly. The block is a single-request engine with busy/done handshaking: one operation in flight, no queue.

## Interface
- `ANCHO`, 32, operand/result width in bits.
- `LARGO`, 5, register index width.

- `clk_i`  in  1  clock; all state updates on posedge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  request valid; sampled only in IDLE.
- `op_i`  in  2  operation: 00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder).
- `rs1_i`  in  ANCHO  operand A / dividend.
- `rs2_i`  in  ANCHO  operand B / divisor.
- `rd_i`  in  LARGO  destination register index.
- `busy_o`  out  1  high from acceptance until the end of the DONE cycle.
- `done_o`  out  1  one-cycle completion pulse.
- `we_o`  out  1  register-file write enable: `done_o && addr_rd_o != 0`.
- `addr_rd_o`  out  LARGO  latched destination index.
- `data_o`  out  ANCHO  result.

## Operation
- FSM states:
  - IDLE: `start_i=1` latches `op_i`, `rs1_i`, `rs2_i`, `rd_i`, loads the iteration counter with ANCHO, and moves to RUN. `start_i=0` stays in IDLE.
  - RUN: one iteration per cycle. The counter decrements; at 0 the state moves to DONE.
  - DONE: the result is registered to `data_o`, `done_o=1`, then IDLE.
- `start_i` outside IDLE is ignored. No error, no effect on the operation in flight.
- Multiply: 2·ANCHO-bit accumulator, shift-add over the bits of B.
  - MUL returns accumulator[ANCHO-1:0].
  - MULHU returns accumulator[2·ANCHO-1:ANCHO].
- Divide: restoring division with an (ANCHO+1)-bit partial remainder.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divisor 0 takes the same path and yields quotient all-ones and remainder = dividend (RISC-V semantics). No special case, same latency.
- `data_o` and `addr_rd_o` hold their values after DONE until the next completion.
- `we_o` is suppressed for `rd=0`. `done_o` still pulses.
- Operands are captured at acceptance. Later changes on `rs1_i`/`rs2_i`/`rd_i` have no effect.

## Timing
- Reset values: `busy_o=0`, `done_o=0`, `we_o=0`, `addr_rd_o=0`, `data_o=0`, state IDLE.
- Latency:
  - Start accepted at posedge k.
  - `busy_o` rises after k.
  - `done_o`/`we_o` are high for exactly the cycle between posedges k+ANCHO+1 and k+ANCHO+2.
  - `busy_o` falls at k+ANCHO+2.
- Throughput: the next start can be accepted at posedge k+ANCHO+2, i.e. one operation per ANCHO+2 cycles.
- All outputs are registered on posedge and stable for the full cycle. The register file's negedge write therefore captures `data_o`/`addr_rd_o`/`we_o` mid-cycle, with half a period of setup.
- Reset asserted mid-RUN or in DONE: operation aborted immediately, outputs to reset values, no `done_o` pulse. After reset deasserts, the first posedge with `start_i=1` is accepted normally.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour above, all four ops.
- Not defined:
  - The divider datapath and its partial-remainder register are not compiled.
  - Ops 10/11 are still accepted, skip RUN (IDLE→DONE), and complete with `data_o=0`. `done_o`/`we_o` behave normally.
  - MUL/MULHU are unchanged.

## Test plan
- MUL 7×6, `rd=5`, start at posedge k: `done_o=1`, `we_o=1`, `addr_rd_o=5`, `data_o=42` in the cycle after posedge k+33; `busy_o` high k+1..k+34.
- MULHU and MUL of 0xFFFFFFFF×0xFFFFFFFF: `data_o=0xFFFFFFFE` and `data_o=0x00000001` respectively.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. All with identical latency.
- MUL 3×3 with `rd=0`: `done_o` pulses, `we_o` stays 0, `data_o=9`. A second `start_i` pulse with different operands mid-RUN is ignored; the result is still 9.
- Reset asserted 10 cycles into a DIVU: all outputs 0 immediately, no `done_o`. A new MUL 2×2 afterwards completes with 4 at nominal latency.
- Without `MULDIV_DIV_EN`: DIVU 100/7 completes with `done_o` one cycle after busy rises, `data_o=0`; MUL 7×6 still returns 42.
